// File: rtl/reg_pair_pipe_scheduler_if.sv
// Request/result bus of the round-robin operand-pair adder pipeline.
// The scheduler connects through the slave modport and the requester/sink side through the master modport.
interface reg_pair_pipe_scheduler_if #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned DATA_WIDTH = 8
);
    localparam int unsigned TAG_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ-1:0]            req_ready;
    logic [N_REQ*DATA_WIDTH-1:0] req_a;
    logic [N_REQ*DATA_WIDTH-1:0] req_b;
    logic                        out_valid;
    logic                        out_ready;
    logic [DATA_WIDTH-1:0]       out_data;
    logic [TAG_W-1:0]            out_tag;
    logic [15:0]                 done_cnt;

    modport master (
        output req_valid, req_a, req_b, out_ready,
        input  req_ready, out_valid, out_data, out_tag, done_cnt
    );

    modport slave (
        input  req_valid, req_a, req_b, out_ready,
        output req_ready, out_valid, out_data, out_tag, done_cnt
    );
endinterface

// File: rtl/reg_pair_pipe_scheduler.sv
// Round-robin scheduler feeding a 2-stage register pipeline that adds an operand pair
// (sum modulo 2^DATA_WIDTH) and returns it tagged with the issuing requester index.
// Optional feature: define REG_PAIR_PIPE_SCHEDULER_CNT_EN to implement the saturating
// completed-transaction counter on done_cnt; otherwise done_cnt is tied to zero.
module reg_pair_pipe_scheduler #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    reg_pair_pipe_scheduler_if.slave bus
);
    localparam int unsigned TAG_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    // Stage 0: captured operand pair
    logic                  v0;
    logic [DATA_WIDTH-1:0] a0;
    logic [DATA_WIDTH-1:0] b0;
    logic [TAG_W-1:0]      tag0;

    // Stage 1: result
    logic                  v1;
    logic [DATA_WIDTH-1:0] sum1;
    logic [TAG_W-1:0]      tag1;

    logic [TAG_W-1:0]      ptr;
    logic [TAG_W-1:0]      ptr_nxt;
    logic                  ld1;
    logic                  acc;
    logic                  gnt_any;
    logic                  grant;
    logic [TAG_W-1:0]      gnt_idx;
    logic [N_REQ-1:0]      gnt_vec;

    logic [DATA_WIDTH-1:0] a_arr [N_REQ];
    logic [DATA_WIDTH-1:0] b_arr [N_REQ];

    // Unpack the flat operand buses into per-requester lanes
    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign a_arr[g] = bus.req_a[g*DATA_WIDTH +: DATA_WIDTH];
        assign b_arr[g] = bus.req_b[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Pipeline advance conditions: stage1 moves when empty or drained, stage0 when empty or moving
    assign ld1   = !v1 || bus.out_ready;
    assign acc   = !v0 || ld1;
    assign grant = acc && gnt_any && !rst;

    // Round-robin search starting at ptr, wrapping modulo N_REQ
    always_comb begin
        int unsigned cand;
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = 32'(ptr) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!gnt_any && bus.req_valid[TAG_W'(cand)]) begin
                gnt_any = 1'b1;
                gnt_idx = TAG_W'(cand);
            end
        end
    end

    // Pointer moves just past the winner
    always_comb begin
        int unsigned nxt;
        nxt = 32'(gnt_idx) + 1;
        if (nxt >= N_REQ) begin
            nxt = 0;
        end
        ptr_nxt = TAG_W'(nxt);
    end

    // One-hot accept towards the winning requester
    always_comb begin
        gnt_vec = '0;
        if (grant) begin
            gnt_vec[gnt_idx] = 1'b1;
        end
    end

    assign bus.req_ready = gnt_vec;
    assign bus.out_valid = v1;
    assign bus.out_data  = sum1;
    assign bus.out_tag   = tag1;

    // Pipeline registers and arbitration pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            v0   <= 1'b0;
            a0   <= '0;
            b0   <= '0;
            tag0 <= '0;
            v1   <= 1'b0;
            sum1 <= '0;
            tag1 <= '0;
            ptr  <= '0;
        end else begin
            if (ld1) begin
                v1   <= v0;
                sum1 <= a0 + b0;
                tag1 <= tag0;
            end
            if (acc) begin
                v0 <= grant;
                if (grant) begin
                    a0   <= a_arr[gnt_idx];
                    b0   <= b_arr[gnt_idx];
                    tag0 <= gnt_idx;
                    ptr  <= ptr_nxt;
                end
            end
        end
    end

`ifdef REG_PAIR_PIPE_SCHEDULER_CNT_EN
    logic [15:0] done_q;

    // Saturating count of output handshakes
    always_ff @(posedge clk) begin
        if (rst) begin
            done_q <= '0;
        end else if (v1 && bus.out_ready && (done_q != 16'hFFFF)) begin
            done_q <= done_q + 16'd1;
        end
    end

    assign bus.done_cnt = done_q;
`else
    assign bus.done_cnt = '0;
`endif

endmodule

// File: tb/tb_reg_pair_pipe_scheduler.sv
// Bench for reg_pair_pipe_scheduler: directed scenarios followed by random traffic,
// all checked against a transaction-queue reference model.
module tb_reg_pair_pipe_scheduler;
    localparam int unsigned N  = 4;
    localparam int unsigned DW = 8;

    logic clk;
    logic rst;

    reg_pair_pipe_scheduler_if #(.N_REQ(N), .DATA_WIDTH(DW)) bus ();

    reg_pair_pipe_scheduler #(.N_REQ(N), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stimulus state
    int rv_mask;
    int opa [N];
    int opb [N];
    bit ordy;

    // Reference model: in-flight transactions oldest first; st=0 waiting, st=1 presented at output
    typedef struct {
        int sum;
        int tag;
        int st;
    } item_t;

    item_t q[$];
    int    m_ptr;
    int    m_cnt;
    int    exp_g;
    bit    s1occ;

    int passed;
    int failed;
    int total;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_done();
`ifdef REG_PAIR_PIPE_SCHEDULER_CNT_EN
        return m_cnt;
`else
        return 0;
`endif
    endfunction

    // Apply inputs, let them settle, compare against the model's view of this cycle
    task automatic step_begin();
        bit s0occ;
        bit accept_ok;
        bus.req_valid = N'(rv_mask);
        bus.req_a     = {8'(opa[3]), 8'(opa[2]), 8'(opa[1]), 8'(opa[0])};
        bus.req_b     = {8'(opb[3]), 8'(opb[2]), 8'(opb[1]), 8'(opb[0])};
        bus.out_ready = ordy;
        #2;
        s0occ = 1'b0;
        foreach (q[j]) if (q[j].st == 0) s0occ = 1'b1;
        s1occ     = (q.size() > 0) && (q[0].st == 1);
        accept_ok = !s0occ || !s1occ || ordy;
        exp_g     = -1;
        if (!rst && accept_ok) begin
            for (int k = 0; k < int'(N); k++) begin
                int i;
                i = (m_ptr + k) % int'(N);
                if (exp_g < 0 && ((rv_mask >> i) & 1) != 0) exp_g = i;
            end
        end
        chk("req_ready", 32'(bus.req_ready), (exp_g < 0) ? 32'd0 : (32'd1 << exp_g));
        chk("out_valid", 32'(bus.out_valid), 32'(s1occ));
        if (s1occ) begin
            chk("out_data", 32'(bus.out_data), 32'(q[0].sum));
            chk("out_tag", 32'(bus.out_tag), 32'(q[0].tag));
        end
        chk("done_cnt", 32'(bus.done_cnt), 32'(exp_done()));
    endtask

    // Advance the model by one clock edge, then step past the edge
    task automatic step_end();
        if (rst) begin
            q.delete();
            m_ptr = 0;
            m_cnt = 0;
        end else begin
            if (s1occ && ordy) begin
                void'(q.pop_front());
                if (m_cnt < 65535) m_cnt++;
            end
            if (!s1occ || ordy) begin
                foreach (q[j]) if (q[j].st == 0) q[j].st = 1;
            end
            if (exp_g >= 0) begin
                q.push_back('{(opa[exp_g] + opb[exp_g]) % 256, exp_g, 0});
                m_ptr = (exp_g + 1) % int'(N);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        step_begin();
        step_end();
    endtask

    task automatic drain();
        rv_mask = 0;
        ordy    = 1'b1;
        repeat (4) tick();
    endtask

    task automatic randomize_ops();
        for (int k = 0; k < int'(N); k++) begin
            opa[k] = int'($urandom_range(0, 255));
            opb[k] = int'($urandom_range(0, 255));
        end
    endtask

    initial begin
        int accepted;
        passed  = 0;
        failed  = 0;
        total   = 0;
        m_ptr   = 0;
        m_cnt   = 0;
        exp_g   = -1;
        s1occ   = 1'b0;
        rv_mask = 0;
        ordy    = 1'b1;
        for (int k = 0; k < int'(N); k++) begin
            opa[k] = 0;
            opb[k] = 0;
        end

        // Reset, with all requesters asserting: no accepts while in reset
        rst = 1'b1;
        @(posedge clk);
        #1;
        rv_mask = 15;
        tick();
        tick();
        rst     = 1'b0;
        rv_mask = 0;
        step_begin();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        step_end();

        // Single request from requester 0
        rv_mask = 1;
        opa[0]  = 'h12;
        opb[0]  = 'h34;
        tick();
        rv_mask = 0;
        tick();
        step_begin();
        chk("single_valid", 32'(bus.out_valid), 32'd1);
        chk("single_data", 32'(bus.out_data), 32'h46);
        chk("single_tag", 32'(bus.out_tag), 32'd0);
        step_end();
        drain();

        // All requesters valid: grants and tags rotate 0,1,2,3,0,1,...
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        rv_mask = 15;
        for (int j = 0; j < 8; j++) begin
            randomize_ops();
            step_begin();
            chk("rr_grant", 32'(bus.req_ready), 32'd1 << (j % 4));
            if (j >= 2) begin
                chk("rr_tag", 32'(bus.out_tag), 32'((j - 2) % 4));
                chk("rr_valid", 32'(bus.out_valid), 32'd1);
            end
            step_end();
        end
        drain();

        // Sum carry is discarded
        rv_mask = 2;
        opa[1]  = 'hFF;
        opb[1]  = 'h02;
        tick();
        rv_mask = 0;
        tick();
        step_begin();
        chk("overflow_data", 32'(bus.out_data), 32'h01);
        chk("overflow_tag", 32'(bus.out_tag), 32'd1);
        step_end();
        drain();

        // Downstream stall: only two transactions fit, then accept drops
        ordy     = 1'b0;
        rv_mask  = 4;
        accepted = 0;
        for (int j = 0; j < 5; j++) begin
            opa[2] = int'($urandom_range(0, 255));
            opb[2] = int'($urandom_range(0, 255));
            step_begin();
            if (bus.req_ready[2]) accepted++;
            step_end();
        end
        chk("stall_accepted", 32'(accepted), 32'd2);
        step_begin();
        chk("stall_ready_low", 32'(bus.req_ready), 32'd0);
        chk("stall_hold_valid", 32'(bus.out_valid), 32'd1);
        step_end();
        drain();

        // Reset while full: pipeline emptied, arbitration restarts at requester 0
        rv_mask = 15;
        ordy    = 1'b0;
        randomize_ops();
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst  = 1'b0;
        ordy = 1'b1;
        step_begin();
        chk("post_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("post_rst_grant", 32'(bus.req_ready), 32'd1);
        step_end();
        drain();

        // Three completions on the counter
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        rv_mask = 8;
        repeat (3) tick();
        drain();
        step_begin();
`ifdef REG_PAIR_PIPE_SCHEDULER_CNT_EN
        chk("done_cnt_three", 32'(bus.done_cnt), 32'd3);
`else
        chk("done_cnt_off", 32'(bus.done_cnt), 32'd0);
`endif
        step_end();

        // Random traffic with random backpressure and occasional resets
        repeat (500) begin
            rv_mask = int'($urandom_range(0, 15));
            randomize_ops();
            ordy = ($urandom_range(0, 3) != 0);
            rst  = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0;
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
